// File: rtl/mem_wb_writeback.sv
// Write-back end of the MEM/WB pipeline: resolves write data/destination, commits
// into the general register file, serves two bypassed ID read ports and counts retired writes.
module mem_wb_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int RA_INDEX   = 31
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] ALUResult_WB,
  input  logic [DATA_WIDTH-1:0] ReadDataFromMem_WB,
  input  logic [DATA_WIDTH-1:0] NextInstruct_WB,
  input  logic [DATA_WIDTH-1:0] ReadData1_WB,
  input  logic [31:0]           Instruction_WB,
  input  logic [ADDR_WIDTH-1:0] WriteRegAddress_WB,
  input  logic [1:0]            MemtoReg_WB,
  input  logic [1:0]            RegDst_WB,
  input  logic                  RegWrite_WB,
  input  logic                  RegWriteSel_WB,
  input  logic                  Zero_WB,
  input  logic [ADDR_WIDTH-1:0] ReadAddr1,
  input  logic [ADDR_WIDTH-1:0] ReadAddr2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic [DATA_WIDTH-1:0] WBData,
  output logic [ADDR_WIDTH-1:0] WBAddr,
  output logic                  WBEnable,
  output logic [31:0]           WBCount
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [31:0]           wb_count_q;
  logic [31:0]           wb_count_d;

  logic [DATA_WIDTH-1:0] wb_data;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic                  wb_enable;
  logic                  unused_instr_bits;

  assign unused_instr_bits = ^{Instruction_WB[31:21], Instruction_WB[10:0]};

  always_comb begin
    wb_data = '0;
    unique case (MemtoReg_WB)
      2'b00:   wb_data = ALUResult_WB;
      2'b01:   wb_data = ReadDataFromMem_WB;
      2'b10:   wb_data = NextInstruct_WB;
      2'b11:   wb_data = ReadData1_WB;
      default: wb_data = '0;
    endcase
  end

  always_comb begin
    wb_addr = '0;
    unique case (RegDst_WB)
      2'b00:   wb_addr = ADDR_WIDTH'(Instruction_WB[20:16]);
      2'b01:   wb_addr = ADDR_WIDTH'(Instruction_WB[15:11]);
      2'b10:   wb_addr = ADDR_WIDTH'(RA_INDEX);
      2'b11:   wb_addr = WriteRegAddress_WB;
      default: wb_addr = '0;
    endcase
  end

  // RegWrite_WB gates first so unknown selects on idle cycles cannot enable a write
  assign wb_enable = RegWrite_WB & (~RegWriteSel_WB | Zero_WB) & (wb_addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wb_enable) begin
      regs_d[wb_addr] = wb_data;
    end
    wb_count_d = wb_count_q + {31'b0, wb_enable};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      regs_q     <= '{default: '0};
      wb_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_count_q <= wb_count_d;
    end
  end

  // Write-first bypass; suppressed during reset so readers see the cleared file
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (!Reset) begin
      if (ReadAddr1 == '0)                      ReadData1 = '0;
      else if (wb_enable && ReadAddr1 == wb_addr) ReadData1 = wb_data;
      else                                      ReadData1 = regs_q[ReadAddr1];
      if (ReadAddr2 == '0)                      ReadData2 = '0;
      else if (wb_enable && ReadAddr2 == wb_addr) ReadData2 = wb_data;
      else                                      ReadData2 = regs_q[ReadAddr2];
    end
  end

  assign WBData   = wb_data;
  assign WBAddr   = wb_addr;
  assign WBEnable = wb_enable;
  assign WBCount  = wb_count_q;

endmodule
